// File: rtl/alu381_pkg.sv
// alu381_pkg: op codes, FSM state type and op classification for alu381_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by the design files: ALU381_GP_EN.
package alu381_pkg;

  localparam logic [2:0] OP_CLR = 3'b000;  // f = 0
  localparam logic [2:0] OP_BMA = 3'b001;  // B + ~A + cin
  localparam logic [2:0] OP_AMB = 3'b010;  // A + ~B + cin
  localparam logic [2:0] OP_ADD = 3'b011;  // A + B + cin
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_SET = 3'b111;  // f = all ones

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic ops are the only ones that use the carry chain and flags.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BMA) || (op == OP_AMB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu381_slice.sv
// alu381_slice: one SLICE-bit slice of the 381 function set.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: i_a/i_b operand slices, i_op function, i_ci slice carry-in;
//   o_f result slice, o_co carry-out, o_c_msb carry into the slice MSB,
//   o_g/o_p slice generate/propagate (present only with ALU381_GP_EN).
module alu381_slice
  import alu381_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_ci,
  output logic [SLICE-1:0] o_f,
  output logic             o_co,
  output logic             o_c_msb
`ifdef ALU381_GP_EN
  ,
  output logic             o_g,
  output logic             o_p
`endif
);

  logic [SLICE-1:0] w_x;
  logic [SLICE-1:0] w_y;
  logic [SLICE:0]   w_sum;
  logic             w_arith;

  always_comb begin
    w_x = i_a;
    w_y = i_b;
    case (i_op)
      OP_BMA: begin
        w_x = i_b;
        w_y = ~i_a;
      end
      OP_AMB: begin
        w_x = i_a;
        w_y = ~i_b;
      end
      default: begin
        w_x = i_a;
        w_y = i_b;
      end
    endcase
  end

  assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{SLICE{1'b0}}, i_ci};
  assign w_arith = is_arith(i_op);

  always_comb begin
    o_f = w_sum[SLICE-1:0];
    case (i_op)
      OP_CLR:  o_f = '0;
      OP_XOR:  o_f = i_a ^ i_b;
      OP_OR:   o_f = i_a | i_b;
      OP_AND:  o_f = i_a & i_b;
      OP_SET:  o_f = '1;
      default: o_f = w_sum[SLICE-1:0];
    endcase
  end

  assign o_co    = w_arith & w_sum[SLICE];
  // Sum MSB = x ^ y ^ c_in, so the carry into the MSB falls out without a second adder.
  assign o_c_msb = w_arith & (w_sum[SLICE-1] ^ w_x[SLICE-1] ^ w_y[SLICE-1]);

`ifdef ALU381_GP_EN
  logic w_prop;
  assign w_prop = &(w_x ^ w_y);
  assign o_p    = w_arith & w_prop;
  // With ci=1 the carry-out is g|p; g and p are exclusive, so masking p recovers g.
  assign o_g    = w_arith & w_sum[SLICE] & ~(i_ci & w_prop);
`endif

endmodule

// File: rtl/alu381_seq.sv
// alu381_seq: WIDTH-bit 381-style ALU evaluated SLICE bits per cycle, LSB slice first.
// Latency: done pulses the cycle after the NSLICE-th edge following acceptance; one op per NSLICE+1 cycles.
// Backpressure: start is accepted only in IDLE/DONE (busy=0); start while busy is dropped, not queued.
// Ports: clk, rst_n (async active-low); start/op/a/b/cin request (latched on accept);
//   busy, done pulse, f result, cout, ovf, zero flags (held between done pulses);
//   g_out/p_out word generate/propagate when ALU381_GP_EN is defined.
module alu381_seq
  import alu381_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero
`ifdef ALU381_GP_EN
  ,
  output logic             g_out,
  output logic             p_out
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;       // shifted right one slice per RUN cycle
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_acc;     // result slices shift in from the top
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [SLICE-1:0] w_fs;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_acc_next;

`ifdef ALU381_GP_EN
  logic r_gcarry;  // ripple carry of the same word with cin forced to 0
  logic r_pall;    // AND of slice propagates so far
  logic r_g;
  logic r_p;
  logic w_g;
  logic w_p;
  logic w_gcarry_next;
  assign w_gcarry_next = w_g | (w_p & r_gcarry);
`endif

  alu381_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .i_a     (r_a[SLICE-1:0]),
    .i_b     (r_b[SLICE-1:0]),
    .i_op    (r_op),
    .i_ci    (r_carry),
    .o_f     (w_fs),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
`ifdef ALU381_GP_EN
    ,
    .o_g     (w_g),
    .o_p     (w_p)
`endif
  );

  // After NSLICE shifts the first slice has reached bit 0.
  generate
    if (NSLICE > 1) begin : g_acc_shift
      assign w_acc_next = {w_fs, r_acc[WIDTH-1:SLICE]};
    end else begin : g_acc_single
      assign w_acc_next = w_fs;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_CLR;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_f      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
`ifdef ALU381_GP_EN
      r_gcarry <= 1'b0;
      r_pall   <= 1'b0;
      r_g      <= 1'b0;
      r_p      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_carry  <= is_arith(op) & cin;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
`ifdef ALU381_GP_EN
            r_gcarry <= 1'b0;
            r_pall   <= 1'b1;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_acc   <= w_acc_next;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
`ifdef ALU381_GP_EN
          r_gcarry <= w_gcarry_next;
          r_pall   <= r_pall & w_p;
`endif
          if (r_idx == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_f     <= w_acc_next;
            // Slice carries are already forced to 0 for non-arithmetic ops.
            r_cout  <= w_co;
            r_ovf   <= w_c_msb ^ w_co;
            r_zero  <= (w_acc_next == '0);
`ifdef ALU381_GP_EN
            r_g     <= w_gcarry_next;
            r_p     <= r_pall & w_p;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign f    = r_f;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
`ifdef ALU381_GP_EN
  assign g_out = r_g;
  assign p_out = r_p;
`endif

endmodule

// File: tb/tb_alu381_seq.sv
// tb_alu381_seq: directed vector table plus handshake/reset sequences for alu381_seq.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_alu381_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic         cout;
  logic         ovf;
  logic         zero;
`ifdef ALU381_GP_EN
  logic         g_out;
  logic         p_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu381_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .f     (f),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
`ifdef ALU381_GP_EN
    ,
    .g_out (g_out),
    .p_out (p_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] f;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic c);
    @(negedge clk);
    op = o;
    a = aa;
    b = bb;
    cin = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after acceptance until done is seen; 20 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd, first, second, cnt;
    logic [W-1:0] fa, f1, f2;

    //            op      a        b        cin   f        cout  ovf   zero
    vt[0]  = '{3'b011, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{3'b010, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{3'b001, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{3'b100, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{3'b111, 16'hF0F0, 16'hFF00, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{3'b000, 16'hF0F0, 16'hFF00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{3'b110, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{3'b101, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{3'b011, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{3'b011, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[10] = '{3'b011, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0};
    vt[11] = '{3'b010, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[12] = '{3'b010, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_f", f, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
`ifdef ALU381_GP_EN
    check("rst_g", g_out, 0);
    check("rst_p", p_out, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      start_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin);
      wait_done(n);
      check($sformatf("v%0d_latency", i), n, 4);
      check($sformatf("v%0d_f", i), f, vt[i].f);
      check($sformatf("v%0d_cout", i), cout, vt[i].cout);
      check($sformatf("v%0d_ovf", i), ovf, vt[i].ovf);
      check($sformatf("v%0d_zero", i), zero, vt[i].zero);
      check($sformatf("v%0d_busy", i), busy, 0);
    end

    // start during RUN is ignored
    start_op(3'b011, 16'h0001, 16'h0002, 1'b0);
    @(posedge clk);
    @(negedge clk);
    op = 3'b111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    fa = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        nd++;
        fa = f;
      end
    end
    check("ign_done_count", nd, 1);
    check("ign_f", fa, 16'h0003);
    check("ign_busy_after", busy, 0);

    // start held through DONE: back-to-back, operand changes during RUN ignored
    @(negedge clk);
    op = 3'b011;
    a = 16'h0001;
    b = 16'h0002;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0010;
    b = 16'h0020;
    cnt = 0;
    first = -1;
    second = -1;
    f1 = '0;
    f2 = '0;
    while (second < 0 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done === 1'b1) begin
        if (first < 0) begin
          first = cnt;
          f1 = f;
        end else begin
          second = cnt;
          f2 = f;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_edge", first, 4);
    check("b2b_first_f", f1, 16'h0003);
    check("b2b_second_edge", second, 9);
    check("b2b_second_f", f2, 16'h0030);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_idle_busy", busy, 0);

    // Operand toggling during RUN
    start_op(3'b011, 16'h0100, 16'h0200, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    check("tog_latency", n, 4);
    check("tog_f", f, 16'h0300);

    // Reset at RUN idx=2
    start_op(3'b011, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_f", f, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_zero", zero, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) nd++;
    end
    check("mid_rst_no_done", nd, 0);
    start_op(3'b011, 16'h1111, 16'h2222, 1'b0);
    wait_done(n);
    check("post_rst_latency", n, 4);
    check("post_rst_f", f, 16'h3333);

`ifdef ALU381_GP_EN
    start_op(3'b011, 16'hFFFF, 16'h0000, 1'b0);
    wait_done(n);
    check("gp1_p", p_out, 1);
    check("gp1_g", g_out, 0);
    start_op(3'b011, 16'h8000, 16'h8000, 1'b0);
    wait_done(n);
    check("gp2_g", g_out, 1);
    check("gp2_p", p_out, 0);
    start_op(3'b101, 16'hFFFF, 16'h0000, 1'b0);
    wait_done(n);
    check("gp3_g", g_out, 0);
    check("gp3_p", p_out, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
